alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator for the ALU execution units (arith, logic, compare, shift).
//  - Accepts one operation command over a valid/ready interface and drives A, B, ALU_FUN and exactly one unit enable.
//  - Captures the unit's registered result on its flag and returns it over a valid/ready response interface.
//  - Sits between the register-file/control path and the ALU units.
// PARAMETERS
//  WIDTH      16        operand width of A/B and of every unit result input
//  RES_WIDTH  2*WIDTH   response data width; unit results are zero-extended
//  TIMEOUT    4         max WAIT cycles for the selected flag before an error response (>=1)
// PORTS
//  CLK           in   1          clock, rising edge
//  RST           in   1          reset, asynchronous, active-low
//  cmd_valid     in   1          command present
//  cmd_ready     out  1          sequencer can accept a command
//  cmd_op        in   4          [3:2] unit: 00 arith, 01 logic, 10 cmp, 11 shift; [1:0] function
//  cmd_a         in   WIDTH      operand A
//  cmd_b         in   WIDTH      operand B
//  A             out  WIDTH      operand A to units
//  B             out  WIDTH      operand B to units
//  ALU_FUN       out  2          function code to units (= cmd_op[1:0])
//  Arith_Enable  out  1          one-hot unit enables, high in ISSUE only
//  Logic_Enable  out  1
//  CMP_Enable    out  1
//  Shift_Enable  out  1
//  Arith_OUT     in   RES_WIDTH  arith result (registered in unit)
//  Logic_OUT     in   WIDTH      logic result (registered in unit)
//  CMP_OUT       in   WIDTH      compare result (registered in unit)
//  Shift_OUT     in   WIDTH      shift result (registered in unit)
//  Arith_Flag    in   1          result-valid flags, one per unit
//  Logic_Flag    in   1
//  CMP_Flag      in   1
//  Shift_Flag    in   1
//  rsp_valid     out  1          response present
//  rsp_ready     in   1          consumer accepts response
//  rsp_data      out  RES_WIDTH  captured result, zero-extended; 0 on error
//  rsp_unit      out  2          unit that produced the response (= cmd_op[3:2])
//  rsp_err       out  1          1 = selected flag not seen within TIMEOUT
// BEHAVIOUR
//  - Reset: all outputs registered and 0, except cmd_ready = 1 (state IDLE).
//    Reset mid-operation drops the command and any pending response, with no flush cycle.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    - IDLE: cmd_ready=1. cmd_valid&cmd_ready latches op/a/b and goes to ISSUE.
//    - ISSUE (1 cycle): A/B/ALU_FUN driven from the latch; the selected enable is 1, the other three 0.
//    - WAIT: all enables 0; A/B/ALU_FUN held; timeout counter increments each cycle.
//      - Selected unit flag = 1: capture its OUT into rsp_data, rsp_err=0, go to RESP.
//      - Counter reaches TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
//    - RESP: rsp_valid=1; rsp_data/unit/err stable until rsp_valid&rsp_ready, then IDLE.
//  - Nominal latency: accept edge -> rsp_valid high 3 cycles later (unit flag seen in 1st WAIT cycle).
//  - Max throughput: one command per 4 cycles with rsp_ready held 1.
//  - cmd_ready=0 outside IDLE; cmd_* ignored outside IDLE.
//  - Flags from non-selected units are ignored, even when asserted simultaneously with the selected flag.
//  - Flag and timeout in the same cycle: the flag wins (rsp_err=0).
//  - Width: WIDTH-bit results are zero-extended into rsp_data. Arith_OUT is taken in full.
//  - Timeout counter width: $clog2(TIMEOUT+1); cleared on entry to WAIT.
// STRUCTURE
//  - Shared package: unit-select codes (ALU_ARITH/LOGIC/CMP/SHIFT), FSM state typedef, ALU_FUN codes.
//  - Single flat module; no sub-module. Enable decode is an inline one-hot case.
// TESTING
//  1. Logic AND: op=4'b0100, a=16'hF0F0, b=16'h0FF0.
//     -> Logic_Enable pulses 1 cycle; rsp_data=32'h0000_00F0, rsp_unit=01, rsp_err=0, rsp_valid 3 cycles after accept.
//  2. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
//     -> rsp_* held stable, cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
//  3. Timeout: op=4'b1100, Shift_Flag tied 0.
//     -> after 4 WAIT cycles rsp_err=1, rsp_data=0, rsp_unit=11.
//  4. Cross-flag: op=4'b1001; CMP_Flag and Logic_Flag both 1 in WAIT, CMP_OUT=16'h0001, Logic_OUT=16'hFFFF.
//     -> rsp_data=32'h1.
//  5. Reset mid-op: assert RST low during WAIT.
//     -> all outputs 0 immediately, cmd_ready=1 after release; no stale response follows.
//  6. Back-to-back: 3 commands with cmd_valid held 1 and rsp_ready=1.
//     -> accepts every 4th cycle; responses in order; exactly one enable pulse per command.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared codes and state type for the ALU command sequencer
//
// Purpose:
//    Unit-select codes (cmd_op[3:2]), ALU_FUN codes per unit (cmd_op[1:0])
//    and the sequencer FSM state type.
// Ports:
//    none (package)

package alu_cmd_sequencer_pkg;

   // Unit select, carried in cmd_op[3:2] and returned on rsp_unit
   localparam logic [1:0] ALU_ARITH = 2'b00;
   localparam logic [1:0] ALU_LOGIC = 2'b01;
   localparam logic [1:0] ALU_CMP   = 2'b10;
   localparam logic [1:0] ALU_SHIFT = 2'b11;

   // ALU_FUN codes, meaning depends on the selected unit
   localparam logic [1:0] FUN_ADD  = 2'b00;
   localparam logic [1:0] FUN_SUB  = 2'b01;
   localparam logic [1:0] FUN_MUL  = 2'b10;
   localparam logic [1:0] FUN_DIV  = 2'b11;
   localparam logic [1:0] FUN_AND  = 2'b00;
   localparam logic [1:0] FUN_OR   = 2'b01;
   localparam logic [1:0] FUN_NAND = 2'b10;
   localparam logic [1:0] FUN_NOR  = 2'b11;
   localparam logic [1:0] FUN_EQ   = 2'b00;
   localparam logic [1:0] FUN_GT   = 2'b01;
   localparam logic [1:0] FUN_LT   = 2'b10;
   localparam logic [1:0] FUN_SHR  = 2'b00;
   localparam logic [1:0] FUN_SHL  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response initiator for the arith/logic/cmp/shift ALU units
//
// Purpose:
//    Accepts one command (cmd_*), drives A/B/ALU_FUN and a one-cycle enable
//    to the selected unit, waits up to TIMEOUT cycles for that unit's flag,
//    and returns the captured result (or an error) on rsp_*.
// Ports:
//    CLK, RST                         clock (rising) / async active-low reset
//    cmd_valid/cmd_ready              command handshake
//    cmd_op[3:0], cmd_a, cmd_b        unit+function, operands
//    A, B, ALU_FUN                    operands/function to the units
//    Arith/Logic/CMP/Shift_Enable     one-hot unit enables (ISSUE only)
//    Arith/Logic/CMP/Shift_OUT        unit results (Arith_OUT is RES_WIDTH)
//    Arith/Logic/CMP/Shift_Flag       unit result-valid flags
//    rsp_valid/rsp_ready              response handshake
//    rsp_data, rsp_unit, rsp_err      result, unit code, timeout error

module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int RES_WIDTH = 2 * WIDTH,
   parameter int TIMEOUT   = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic [WIDTH-1:0]     cmd_a,
   input  logic [WIDTH-1:0]     cmd_b,
   output logic [WIDTH-1:0]     A,
   output logic [WIDTH-1:0]     B,
   output logic [1:0]           ALU_FUN,
   output logic                 Arith_Enable,
   output logic                 Logic_Enable,
   output logic                 CMP_Enable,
   output logic                 Shift_Enable,
   input  logic [RES_WIDTH-1:0] Arith_OUT,
   input  logic [WIDTH-1:0]     Logic_OUT,
   input  logic [WIDTH-1:0]     CMP_OUT,
   input  logic [WIDTH-1:0]     Shift_OUT,
   input  logic                 Arith_Flag,
   input  logic                 Logic_Flag,
   input  logic                 CMP_Flag,
   input  logic                 Shift_Flag,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [RES_WIDTH-1:0] rsp_data,
   output logic [1:0]           rsp_unit,
   output logic                 rsp_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Last WAIT cycle: the counter would step to TIMEOUT on this edge
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   seq_state_t             state;
   seq_state_t             state_nxt;
   logic [1:0]             unit_q;
   logic [CNT_W-1:0]       wait_cnt;
   logic                   sel_flag;
   logic [RES_WIDTH-1:0]   sel_out;
   logic                   accept;
   logic                   timeout_hit;

   assign accept      = cmd_valid && cmd_ready;
   assign timeout_hit = (wait_cnt == CNT_LAST);

   // Only the latched unit's flag/result is looked at; others are ignored
   always_comb begin
      sel_flag = 1'b0;
      sel_out  = '0;
      case (unit_q)
         ALU_ARITH: begin
            sel_flag = Arith_Flag;
            sel_out  = Arith_OUT;
         end
         ALU_LOGIC: begin
            sel_flag = Logic_Flag;
            sel_out  = RES_WIDTH'(Logic_OUT);
         end
         ALU_CMP: begin
            sel_flag = CMP_Flag;
            sel_out  = RES_WIDTH'(CMP_OUT);
         end
         default: begin
            sel_flag = Shift_Flag;
            sel_out  = RES_WIDTH'(Shift_OUT);
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (sel_flag || timeout_hit) state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // All outputs are registered from state_nxt so they line up with the
   // state they belong to rather than lagging it by a cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cmd_ready    <= 1'b1;
         A            <= '0;
         B            <= '0;
         ALU_FUN      <= 2'b00;
         unit_q       <= 2'b00;
         Arith_Enable <= 1'b0;
         Logic_Enable <= 1'b0;
         CMP_Enable   <= 1'b0;
         Shift_Enable <= 1'b0;
         wait_cnt     <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_unit     <= 2'b00;
         rsp_err      <= 1'b0;
      end else begin
         cmd_ready    <= (state_nxt == ST_IDLE);
         rsp_valid    <= (state_nxt == ST_RESP);
         Arith_Enable <= 1'b0;
         Logic_Enable <= 1'b0;
         CMP_Enable   <= 1'b0;
         Shift_Enable <= 1'b0;

         if (accept) begin
            A       <= cmd_a;
            B       <= cmd_b;
            ALU_FUN <= cmd_op[1:0];
            unit_q  <= cmd_op[3:2];
            case (cmd_op[3:2])
               ALU_ARITH: Arith_Enable <= 1'b1;
               ALU_LOGIC: Logic_Enable <= 1'b1;
               ALU_CMP:   CMP_Enable   <= 1'b1;
               default:   Shift_Enable <= 1'b1;
            endcase
         end

         if (state == ST_ISSUE) begin
            wait_cnt <= '0;
         end

         if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            // A flag arriving on the last allowed cycle still counts as success
            if (sel_flag) begin
               rsp_data <= sel_out;
               rsp_unit <= unit_q;
               rsp_err  <= 1'b0;
            end else if (timeout_hit) begin
               rsp_data <= '0;
               rsp_unit <= unit_q;
               rsp_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer

module tb_alu_cmd_sequencer;

   localparam int WIDTH     = 16;
   localparam int RES_WIDTH = 32;
   localparam int TIMEOUT   = 4;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b0;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [3:0]           cmd_op = 4'h0;
   logic [WIDTH-1:0]     cmd_a = '0;
   logic [WIDTH-1:0]     cmd_b = '0;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [1:0]           ALU_FUN;
   logic                 Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
   logic [RES_WIDTH-1:0] Arith_OUT = '0;
   logic [WIDTH-1:0]     Logic_OUT = '0;
   logic [WIDTH-1:0]     CMP_OUT = '0;
   logic [WIDTH-1:0]     Shift_OUT = '0;
   logic                 Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [RES_WIDTH-1:0] rsp_data;
   logic [1:0]           rsp_unit;
   logic                 rsp_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int en_pulses = 0;
   int last_acc = 0;

   alu_cmd_sequencer #(.WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
      .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
      .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
      .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_unit(rsp_unit), .rsp_err(rsp_err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc       <= cyc + 1;
      en_pulses <= en_pulses + int'(Arith_Enable) + int'(Logic_Enable)
                   + int'(CMP_Enable) + int'(Shift_Enable);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // What an ideal unit would return for this command
   function automatic logic [31:0] unit_result(input logic [3:0] op, input logic [15:0] a,
                                               input logic [15:0] b);
      logic [31:0] x, y;
      logic [15:0] r;
      x = {16'h0, a};
      y = {16'h0, b};
      r = 16'h0;
      case (op)
         4'b0000: return x + y;
         4'b0001: return x - y;
         4'b0010: return x * y;
         4'b0011: return (b == 16'h0) ? 32'h0 : x / y;
         4'b0100: r = a & b;
         4'b0101: r = a | b;
         4'b0110: r = ~(a & b);
         4'b0111: r = ~(a | b);
         4'b1000: r = (a == b) ? 16'h1 : 16'h0;
         4'b1001: r = (a > b) ? 16'h1 : 16'h0;
         4'b1010: r = (a < b) ? 16'h1 : 16'h0;
         4'b1100: r = a >> b[3:0];
         4'b1101: r = a << b[3:0];
         default: r = 16'h0;
      endcase
      return {16'h0, r};
   endfunction

   // Unit outputs for one cycle: selected unit flag/result, optional noise on the others
   task automatic drive_outs(input logic [1:0] unit, input bit flag_on, input logic [31:0] val,
                             input bit noise);
      Arith_OUT  = noise ? 32'hFFFF_FFFF : $urandom;
      Logic_OUT  = noise ? 16'hFFFF : 16'($urandom);
      CMP_OUT    = noise ? 16'hFFFF : 16'($urandom);
      Shift_OUT  = noise ? 16'hFFFF : 16'($urandom);
      Arith_Flag = noise;
      Logic_Flag = noise;
      CMP_Flag   = noise;
      Shift_Flag = noise;
      case (unit)
         2'b00: begin Arith_Flag = flag_on; Arith_OUT = flag_on ? val : $urandom; end
         2'b01: begin Logic_Flag = flag_on; Logic_OUT = flag_on ? val[15:0] : 16'($urandom); end
         2'b10: begin CMP_Flag = flag_on;   CMP_OUT = flag_on ? val[15:0] : 16'($urandom); end
         default: begin Shift_Flag = flag_on; Shift_OUT = flag_on ? val[15:0] : 16'($urandom); end
      endcase
   endtask

   // One full command: called at a negedge with the DUT idle; returns at a negedge, DUT idle.
   // lat = WAIT cycle (1-based) in which the unit flag rises; 0 or > TIMEOUT means never.
   task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input bit noise, input int bp,
                         input bit nxt_v, input logic [3:0] nxt_op, input logic [15:0] nxt_a,
                         input logic [15:0] nxt_b, input bit chk_gap);
      logic [31:0] res, exp_data;
      bit          exp_err;
      int          exp_lat, n, p0;
      logic [3:0]  exp_en;
      res      = unit_result(op, a, b);
      exp_err  = (lat < 1) || (lat > TIMEOUT);
      exp_data = exp_err ? 32'h0 : res;
      exp_lat  = 2 + (exp_err ? TIMEOUT : lat);
      exp_en   = 4'b1000 >> op[3:2];

      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      rsp_ready = (bp == 0);
      drive_outs(op[3:2], 1'b0, 32'h0, 1'b0);
      chk("cmd_ready_idle", cmd_ready, 1);
      if (chk_gap) chk("accept_gap", cyc - last_acc, 4);
      last_acc = cyc;
      p0 = en_pulses;
      @(posedge CLK); @(negedge CLK);
      cmd_valid = nxt_v; cmd_op = nxt_op; cmd_a = nxt_a; cmd_b = nxt_b;
      chk("issue_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, exp_en);
      chk("issue_a", A, a);
      chk("issue_b", B, b);
      chk("issue_fun", ALU_FUN, op[1:0]);
      chk("issue_cmd_ready", cmd_ready, 0);
      n = 1;
      while (!rsp_valid && n < exp_lat + 3) begin
         drive_outs(op[3:2], (n >= 2) && ((n - 1) == lat), res, noise && (n >= 2));
         @(posedge CLK); @(negedge CLK);
         n++;
         if (!rsp_valid)
            chk("wait_en_a", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, A}, {4'b0, a});
      end
      drive_outs(op[3:2], 1'b0, 32'h0, 1'b0);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_latency", n, exp_lat);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_unit", rsp_unit, op[3:2]);
      chk("rsp_err", rsp_err, exp_err);
      chk("resp_cmd_ready", cmd_ready, 0);
      for (int k = 1; k < bp; k++) begin
         @(posedge CLK); @(negedge CLK);
         chk("bp_hold", {cmd_ready, rsp_valid, rsp_err, rsp_unit, rsp_data},
             {1'b0, 1'b1, exp_err, op[3:2], exp_data});
      end
      rsp_ready = 1'b1;
      @(posedge CLK); @(negedge CLK);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("enable_pulses", en_pulses - p0, 1);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;

      // Reset state
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ops", {A, B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, 0);
      chk("rst_rsp", {rsp_valid, rsp_data, rsp_unit, rsp_err}, 0);
      RST = 1'b1;
      @(negedge CLK);

      // Logic AND, nominal latency
      do_cmd(4'b0100, 16'hF0F0, 16'h0FF0, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0);
      // Backpressure for 5 cycles
      do_cmd(4'b0001, 16'h1234, 16'h0F0F, 2, 0, 5, 0, 4'h0, 16'h0, 16'h0, 0);
      // Timeout, shift flag never rises
      do_cmd(4'b1100, 16'h8000, 16'h0003, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0);
      // Cross-flag: CMP selected, other units flag with all-ones results
      do_cmd(4'b1001, 16'h0005, 16'h0003, 1, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0);
      // Flag on the last allowed WAIT cycle, then one cycle too late
      do_cmd(4'b0010, 16'hFFFF, 16'hFFFF, TIMEOUT, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0);
      do_cmd(4'b0111, 16'h00FF, 16'h0F00, TIMEOUT + 1, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0);

      // Reset during WAIT
      cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_a = 16'h1111; cmd_b = 16'h2222; rsp_ready = 1'b1;
      @(posedge CLK); @(negedge CLK);
      cmd_valid = 1'b0;
      drive_outs(2'b01, 1'b0, 32'h0, 1'b0);
      @(posedge CLK); @(negedge CLK);
      drive_outs(2'b01, 1'b1, 32'h0000_ABCD, 1'b0);
      RST = 1'b0;
      #1;
      chk("rstmid_ops", {A, B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, 0);
      chk("rstmid_rsp", {rsp_valid, rsp_data, rsp_unit, rsp_err}, 0);
      @(negedge CLK);
      RST = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge CLK); @(negedge CLK);
         chk("rstmid_no_stale", {cmd_ready, rsp_valid}, 2'b10);
      end
      drive_outs(2'b01, 1'b0, 32'h0, 1'b0);

      // Back-to-back with cmd_valid held high
      do_cmd(4'b0000, 16'h1000, 16'h0234, 1, 0, 0, 1, 4'b0101, 16'h00F0, 16'h0F00, 0);
      do_cmd(4'b0101, 16'h00F0, 16'h0F00, 1, 0, 0, 1, 4'b1101, 16'h0001, 16'h0004, 1);
      do_cmd(4'b1101, 16'h0001, 16'h0004, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 1);

      // Randomized commands
      for (int i = 0; i < 24; i++) begin
         rop = 4'($urandom);
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         do_cmd(rop, ra, rb, $urandom_range(0, TIMEOUT + 1), 1'($urandom),
                $urandom_range(0, 2), 0, 4'h0, 16'h0, 16'h0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
